// File: rtl/jk_excite_counter.sv
// rtl/jk_excite_counter.sv - modulo-N up/down counter producing JK excitation with feedback tracking
module jk_excite_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             track_err
);

  // Largest legal count; MODULUS == 2**WIDTH truncates to all-ones, giving natural binary wrap.
  localparam logic [WIDTH-1:0] LP_MAX  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] LP_ZERO = '0;
  localparam logic [WIDTH-1:0] LP_ONE  = WIDTH'(1);

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic             r_armed;
  logic             r_err;

  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_excite;
  logic             w_at_max;
  logic             w_at_zero;
  logic             w_tc;

  assign w_at_max  = (r_count == LP_MAX);
  assign w_at_zero = (r_count == LP_ZERO);

  // Next count: load (clamped) beats enable; direction picks the wrap boundary.
  always_comb begin
    w_next = r_count;
    if (load) begin
      w_next = (load_val > LP_MAX) ? LP_MAX : load_val;
    end else if (en && up) begin
      w_next = w_at_max ? LP_ZERO : (r_count + LP_ONE);
    end else if (en) begin
      w_next = w_at_zero ? LP_MAX : (r_count - LP_ONE);
    end
  end

  // Toggle exactly the bits that change; in reset, toggle the set bits so a bank at count lands on 0.
  always_comb begin
    w_excite = reset ? r_count : (r_count ^ w_next);
  end

  // Terminal count only when this edge will actually wrap.
  always_comb begin
    w_tc = 1'b0;
    if (!reset && !load && en) begin
      w_tc = up ? w_at_max : w_at_zero;
    end
  end

  // Counter state, wrap pulse and the sticky feedback checker.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= LP_ZERO;
      r_wrap  <= 1'b0;
      r_armed <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_count <= w_next;
      r_wrap  <= w_tc;
      r_armed <= 1'b1;
      if (r_armed && (q_fb != r_count)) begin
        r_err <= 1'b1;
      end
    end
  end

  assign j_out     = w_excite;
  assign k_out     = w_excite;
  assign count     = r_count;
  assign tc        = w_tc;
  assign wrap      = r_wrap;
  assign track_err = r_err;

endmodule

// File: tb/tb_jk_excite_counter.sv
// tb/tb_jk_excite_counter.sv - randomized self-checking bench for jk_excite_counter
module tb_jk_excite_counter;

  localparam int W   = 4;
  localparam int MOD = 10;

  logic         clk = 1'b0;
  logic         reset, en, up, load;
  logic [W-1:0] load_val, q_fb;
  logic [W-1:0] j_out, k_out, count;
  logic         tc, wrap, track_err;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int           m_count = 0;
  bit           m_wrap = 0, m_err = 0, m_armed = 0;
  logic [W-1:0] bank_q = '0;
  int           e_next;
  bit           e_tc;
  logic [W-1:0] e_jk;

  jk_excite_counter #(.WIDTH(W), .MODULUS(MOD)) dut (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(load_val), .q_fb(q_fb),
    .j_out(j_out), .k_out(k_out), .count(count),
    .tc(tc), .wrap(wrap), .track_err(track_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_in(input bit r, input bit l, input logic [W-1:0] lv,
                        input bit e, input bit u, input logic [W-1:0] f);
    reset = r; load = l; load_val = lv; en = e; up = u;
    q_fb = bank_q ^ f;
    if (r) begin
      e_next = 0; e_tc = 0;
    end else if (l) begin
      e_next = (int'(lv) > MOD - 1) ? MOD - 1 : int'(lv); e_tc = 0;
    end else if (e && u) begin
      e_next = (m_count + 1) % MOD; e_tc = (m_count == MOD - 1);
    end else if (e) begin
      e_next = (m_count + MOD - 1) % MOD; e_tc = (m_count == 0);
    end else begin
      e_next = m_count; e_tc = 0;
    end
    e_jk = r ? W'(m_count) : W'(m_count ^ e_next);
    @(negedge clk);
  endtask

  task automatic tick();
    logic [W-1:0] j, k;
    j = j_out; k = k_out;
    @(posedge clk);
    if (reset) begin
      m_err = 0; m_armed = 0; m_wrap = 0;
    end else begin
      if (m_armed && q_fb !== W'(m_count)) m_err = 1;
      m_armed = 1;
      m_wrap  = e_tc;
    end
    m_count = e_next;
    for (int i = 0; i < W; i++) begin
      if (j[i] && k[i]) bank_q[i] = ~bank_q[i];
      else if (j[i])    bank_q[i] = 1'b1;
      else if (k[i])    bank_q[i] = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    set_in(1, 0, '0, 0, 0, '0);
    tick();
    set_in(1, 1, 4'hF, 1, 1, '0);
    n_checks++; if (tc !== 1'b0) begin n_errors++; $display("FAIL reset_tc got=%b exp=0", tc); end
    n_checks++; if (j_out !== 4'h0 || k_out !== 4'h0) begin n_errors++; $display("FAIL reset_jk got=%h/%h exp=0", j_out, k_out); end
    tick();
    bank_q = '0;
    n_checks++; if (count !== 4'h0) begin n_errors++; $display("FAIL reset_count got=%h exp=0", count); end
    n_checks++; if (wrap !== 1'b0) begin n_errors++; $display("FAIL reset_wrap got=%b exp=0", wrap); end
    n_checks++; if (track_err !== 1'b0) begin n_errors++; $display("FAIL reset_err got=%b exp=0", track_err); end
  endtask

  task automatic test_count_up();
    for (int n = 0; n < 12; n++) begin
      set_in(0, 0, '0, 1, 1, '0);
      n_checks++; if (tc !== e_tc) begin n_errors++; $display("FAIL up_tc n=%0d got=%b exp=%b", n, tc, e_tc); end
      n_checks++; if (j_out !== e_jk || k_out !== e_jk) begin n_errors++; $display("FAIL up_jk n=%0d got=%h/%h exp=%h", n, j_out, k_out, e_jk); end
      if (m_count == 7) begin
        n_checks++; if (j_out !== 4'hF) begin n_errors++; $display("FAIL up_jk_at7 got=%h exp=f", j_out); end
      end
      tick();
      n_checks++; if (count !== W'(m_count)) begin n_errors++; $display("FAIL up_count n=%0d got=%h exp=%h", n, count, W'(m_count)); end
      n_checks++; if (wrap !== m_wrap) begin n_errors++; $display("FAIL up_wrap n=%0d got=%b exp=%b", n, wrap, m_wrap); end
    end
    n_checks++; if (count !== 4'h2) begin n_errors++; $display("FAIL up_final got=%h exp=2", count); end
  endtask

  task automatic test_down_wrap();
    int pulses = 0;
    set_in(0, 1, 4'h0, 0, 0, '0);
    tick();
    n_checks++; if (count !== 4'h0) begin n_errors++; $display("FAIL down_load got=%h exp=0", count); end
    for (int n = 0; n < 3; n++) begin
      set_in(0, 0, '0, 1, 0, '0);
      n_checks++; if (tc !== e_tc) begin n_errors++; $display("FAIL down_tc n=%0d got=%b exp=%b", n, tc, e_tc); end
      if (m_count == 0) begin
        n_checks++; if (j_out !== 4'h9 || k_out !== 4'h9) begin n_errors++; $display("FAIL down_jk_at0 got=%h/%h exp=9", j_out, k_out); end
      end
      tick();
      if (wrap === 1'b1) pulses++;
      n_checks++; if (count !== W'(m_count)) begin n_errors++; $display("FAIL down_count n=%0d got=%h exp=%h", n, count, W'(m_count)); end
    end
    n_checks++; if (pulses != 1) begin n_errors++; $display("FAIL down_wrap_pulses got=%0d exp=1", pulses); end
  endtask

  task automatic test_load_clamp();
    set_in(0, 1, 4'hE, 1, 1, '0);
    n_checks++; if (tc !== 1'b0) begin n_errors++; $display("FAIL clamp_tc got=%b exp=0", tc); end
    tick();
    n_checks++; if (count !== 4'h9) begin n_errors++; $display("FAIL clamp_count got=%h exp=9", count); end
    n_checks++; if (wrap !== 1'b0) begin n_errors++; $display("FAIL clamp_wrap got=%b exp=0", wrap); end
    set_in(0, 0, '0, 0, 1, '0);
    n_checks++; if (j_out !== 4'h0 || k_out !== 4'h0) begin n_errors++; $display("FAIL hold_jk got=%h/%h exp=0", j_out, k_out); end
    tick();
    n_checks++; if (count !== 4'h9) begin n_errors++; $display("FAIL hold_count got=%h exp=9", count); end
  endtask

  task automatic test_boundary_flip();
    reset = 0; load = 0; en = 1; up = 1;
    #1;
    n_checks++; if (tc !== 1'b1) begin n_errors++; $display("FAIL flip_tc_up got=%b exp=1", tc); end
    set_in(0, 0, '0, 1, 0, '0);
    n_checks++; if (tc !== 1'b0) begin n_errors++; $display("FAIL flip_tc_down got=%b exp=0", tc); end
    tick();
    n_checks++; if (count !== 4'h8) begin n_errors++; $display("FAIL flip_count got=%h exp=8", count); end
    n_checks++; if (wrap !== 1'b0) begin n_errors++; $display("FAIL flip_wrap got=%b exp=0", wrap); end
  endtask

  task automatic test_random_track();
    for (int n = 0; n < 40; n++) begin
      bit l, e, u;
      logic [W-1:0] lv;
      l  = ($urandom_range(0, 7) == 0);
      lv = W'($urandom);
      e  = ($urandom_range(0, 3) != 0);
      u  = 1'($urandom);
      set_in(0, l, lv, e, u, '0);
      n_checks++; if (tc !== e_tc) begin n_errors++; $display("FAIL rnd_tc n=%0d got=%b exp=%b", n, tc, e_tc); end
      n_checks++; if (j_out !== e_jk || k_out !== e_jk) begin n_errors++; $display("FAIL rnd_jk n=%0d got=%h/%h exp=%h", n, j_out, k_out, e_jk); end
      tick();
      n_checks++; if (count !== W'(m_count)) begin n_errors++; $display("FAIL rnd_count n=%0d got=%h exp=%h", n, count, W'(m_count)); end
      n_checks++; if (wrap !== m_wrap) begin n_errors++; $display("FAIL rnd_wrap n=%0d got=%b exp=%b", n, wrap, m_wrap); end
      n_checks++; if (track_err !== m_err) begin n_errors++; $display("FAIL rnd_err n=%0d got=%b exp=%b", n, track_err, m_err); end
    end
    n_checks++; if (track_err !== 1'b0) begin n_errors++; $display("FAIL rnd_err_clean got=%b exp=0", track_err); end
  endtask

  task automatic test_fault();
    set_in(0, 0, '0, 1, 1, 4'b0100);
    tick();
    n_checks++; if (track_err !== 1'b1) begin n_errors++; $display("FAIL fault_set got=%b exp=1", track_err); end
    for (int n = 0; n < 3; n++) begin
      set_in(0, 0, '0, 1, 0, '0);
      tick();
      n_checks++; if (track_err !== m_err) begin n_errors++; $display("FAIL fault_sticky n=%0d got=%b exp=%b", n, track_err, m_err); end
    end
  endtask

  task automatic test_midrun_reset();
    set_in(0, 1, 4'h6, 0, 0, '0);
    tick();
    n_checks++; if (count !== 4'h6) begin n_errors++; $display("FAIL mid_load got=%h exp=6", count); end
    set_in(1, 1, 4'hF, 1, 1, '0);
    n_checks++; if (j_out !== 4'h6 || k_out !== 4'h6) begin n_errors++; $display("FAIL mid_reset_jk got=%h/%h exp=6", j_out, k_out); end
    n_checks++; if (tc !== 1'b0) begin n_errors++; $display("FAIL mid_reset_tc got=%b exp=0", tc); end
    tick();
    n_checks++; if (count !== 4'h0) begin n_errors++; $display("FAIL mid_count got=%h exp=0", count); end
    n_checks++; if (wrap !== 1'b0) begin n_errors++; $display("FAIL mid_wrap got=%b exp=0", wrap); end
    n_checks++; if (track_err !== 1'b0) begin n_errors++; $display("FAIL mid_err got=%b exp=0", track_err); end
    n_checks++; if (bank_q !== 4'h0) begin n_errors++; $display("FAIL mid_bank got=%h exp=0", bank_q); end
    set_in(0, 0, '0, 1, 1, 4'b0100);
    tick();
    n_checks++; if (track_err !== 1'b0) begin n_errors++; $display("FAIL arm_skip got=%b exp=0", track_err); end
    n_checks++; if (count !== 4'h1) begin n_errors++; $display("FAIL arm_count got=%h exp=1", count); end
    set_in(0, 0, '0, 1, 1, '0);
    tick();
    n_checks++; if (track_err !== 1'b0) begin n_errors++; $display("FAIL arm_follow got=%b exp=0", track_err); end
  endtask

  initial begin
    reset = 1; en = 0; up = 0; load = 0; load_val = '0; q_fb = '0;
    #1;
    test_reset();
    test_count_up();
    test_down_wrap();
    test_load_clamp();
    test_boundary_flip();
    test_random_track();
    test_fault();
    test_midrun_reset();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
